// File: rtl/alu_cmd_issuer_if.sv
// Purpose: command, ALU and TX-byte signal bundle of alu_cmd_issuer.
// Latency: none, wires only.
// Backpressure: CMD_VALID/CMD_READY on the command side, TX_VALID/TX_READY on the byte side.
// Ports: master = issuer view (takes CMD_*, drives ALU_*, TX_*, BUSY, TIMEOUT_ERR);
//        slave  = environment view (control path, ALU and serial transmitter).
interface alu_cmd_issuer_if #(
  parameter int IN_DATA_WIDTH   = 8,
  parameter int Arith_OUT_WIDTH = 16
);
  logic                       CMD_VALID;
  logic                       CMD_READY;
  logic [IN_DATA_WIDTH-1:0]   CMD_A;
  logic [IN_DATA_WIDTH-1:0]   CMD_B;
  logic [3:0]                 CMD_FUNC;
  logic [IN_DATA_WIDTH-1:0]   ALU_A;
  logic [IN_DATA_WIDTH-1:0]   ALU_B;
  logic [3:0]                 ALU_FUNC;
  logic                       ALU_EN;
  logic [Arith_OUT_WIDTH-1:0] ALU_OUT;
  logic                       ALU_OUT_VALID;
  logic [7:0]                 TX_DATA;
  logic                       TX_VALID;
  logic                       TX_READY;
  logic                       BUSY;
  logic                       TIMEOUT_ERR;

  modport master (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUNC, ALU_OUT, ALU_OUT_VALID, TX_READY,
    output CMD_READY, ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_DATA, TX_VALID, BUSY, TIMEOUT_ERR
  );

  modport slave (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUNC, ALU_OUT, ALU_OUT_VALID, TX_READY,
    input  CMD_READY, ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_DATA, TX_VALID, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Purpose: takes one ALU command, pulses ALU_EN, waits (bounded) for the result and
//          streams it out as one byte (logic/other classes) or two bytes LSB first (arithmetic class).
// Latency: accept edge k -> ALU_EN cycle k+1 -> TX_VALID from cycle (valid cycle)+1; one command in flight.
// Backpressure: CMD_READY only in IDLE; each TX byte is held stable until TX_READY.
// Ports: CLK, RST (sync, active-high) plus the bus interface (master modport).
module alu_cmd_issuer #(
  parameter int IN_DATA_WIDTH   = 8,
  parameter int Arith_OUT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input logic              CLK,
  input logic              RST,
  alu_cmd_issuer_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen during the final allowed WAIT cycle (counter is 0 in WAIT cycle 1).
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND_LO,
    S_SEND_HI
  } state_t;

  state_t                   state_q, state_d;
  logic [IN_DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [IN_DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]               alu_func_q, alu_func_d;
  logic [15:0]              res_q, res_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     alu_en_q, alu_en_d;
  logic                     tx_vld_q, tx_vld_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     busy_q, busy_d;
  logic                     timeout_err_q, timeout_err_d;

  logic [Arith_OUT_WIDTH-1:0] alu_out_w;
  assign alu_out_w = bus.ALU_OUT;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_func_d    = alu_func_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // CMD_READY is high throughout IDLE, so valid alone completes the handshake.
        if (bus.CMD_VALID) begin
          alu_a_d    = bus.CMD_A;
          alu_b_d    = bus.CMD_B;
          alu_func_d = bus.CMD_FUNC;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Saturating so the counter can never wrap.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        // A valid in the last allowed cycle wins over the timeout.
        if (bus.ALU_OUT_VALID) begin
          res_d   = 16'(alu_out_w);
          state_d = S_SEND_LO;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_SEND_LO: begin
        if (bus.TX_READY) begin
          state_d = (alu_func_q[3:2] == 2'b00) ? S_SEND_HI : S_IDLE;
        end
      end
      S_SEND_HI: begin
        if (bus.TX_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so they equal a Moore
    // decode of the state register without any combinational glitching.
    cmd_ready_d = (state_d == S_IDLE);
    alu_en_d    = (state_d == S_ISSUE);
    tx_vld_d    = (state_d == S_SEND_LO) || (state_d == S_SEND_HI);
    busy_d      = (state_d != S_IDLE);

    tx_data_d = tx_data_q;
    if (state_d == S_SEND_LO) begin
      tx_data_d = res_d[7:0];
    end else if (state_d == S_SEND_HI) begin
      tx_data_d = res_d[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      alu_en_q      <= 1'b0;
      tx_vld_q      <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_func_q    <= alu_func_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      alu_en_q      <= alu_en_d;
      tx_vld_q      <= tx_vld_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.CMD_READY   = cmd_ready_q;
  assign bus.ALU_A       = alu_a_q;
  assign bus.ALU_B       = alu_b_q;
  assign bus.ALU_FUNC    = alu_func_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.TX_VALID    = tx_vld_q;
  assign bus.BUSY        = busy_q;
  assign bus.TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Purpose: self-checking bench for alu_cmd_issuer with a transaction-level reference model.
// Latency: model predicts ALU_EN, first TX cycle and timeout cycle from the accept/enable cycles.
// Backpressure: random TX_READY stalls, held CMD_VALID, stray ALU valids and random resets.
module tb_alu_cmd_issuer;
  localparam int TC  = 15;
  localparam int INF = 2147483647;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_cmd_issuer_if #(.IN_DATA_WIDTH(8), .Arith_OUT_WIDTH(16)) bus ();

  alu_cmd_issuer #(
    .IN_DATA_WIDTH  (8),
    .Arith_OUT_WIDTH(16),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;

  // Reference model state (cycle numbers of expected events).
  int         exp_en_cyc = -1, exp_tx_start = -1, exp_to_cyc = -1, alu_vld_cyc = -1;
  int         idle_from = 0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_f = '0;
  logic [15:0] alu_val = '0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  bit         started = 0, rst_chk = 0, cmd_taken = 0, stray_en = 0;
  bit         prev_vld = 0, prev_rdy = 0, prev_rst = 0;
  logic [7:0] prev_data = '0;
  int         force_d = 0;
  int         last_accept = -1, last_en = -1, last_rise = -1, last_to = -1;
  logic       last_to_rdy = 1'b0;
  logic [7:0] last_alu_a = '0, last_alu_b = '0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // What the stand-in ALU computes; the issuer only transports it.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f[3:2])
      2'b00:   alu_fn = (f[1:0] == 2'b00) ? 16'(a) + 16'(b) : 16'(a) * 16'(b);
      2'b01:   alu_fn = 16'(a & b);
      2'b10:   alu_fn = {a, b};
      default: alu_fn = 16'(a ^ b);
    endcase
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Stand-in ALU: answers when the model scheduled it, plus stray valids while idle.
  initial begin
    bus.ALU_OUT_VALID = 1'b0;
    bus.ALU_OUT       = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (cyc == alu_vld_cyc) begin
        bus.ALU_OUT_VALID = 1'b1;
        bus.ALU_OUT       = alu_val;
      end else begin
        bus.ALU_OUT_VALID = stray_en && bus.CMD_READY && ($urandom % 5 == 0);
        bus.ALU_OUT       = 16'($urandom);
      end
    end
  end

  // Compare process and model update, once per cycle away from the active edge.
  initial begin : monitor
    int n, d;
    forever begin
      @(negedge CLK);
      n = cyc;
      if (started) begin
        if (rst_chk) begin
          chk(bus.ALU_EN == 1'b0,      "rst_alu_en",    bus.ALU_EN, 0);
          chk(bus.TX_VALID == 1'b0,    "rst_tx_valid",  bus.TX_VALID, 0);
          chk(bus.BUSY == 1'b0,        "rst_busy",      bus.BUSY, 0);
          chk(bus.TIMEOUT_ERR == 1'b0, "rst_timeout",   bus.TIMEOUT_ERR, 0);
          chk(bus.CMD_READY == 1'b1,   "rst_cmd_ready", bus.CMD_READY, 1);
          chk(bus.ALU_A == 8'h00,      "rst_alu_a",     bus.ALU_A, 0);
          chk(bus.ALU_B == 8'h00,      "rst_alu_b",     bus.ALU_B, 0);
          chk(bus.ALU_FUNC == 4'h0,    "rst_alu_func",  bus.ALU_FUNC, 0);
          chk(bus.TX_DATA == 8'h00,    "rst_tx_data",   bus.TX_DATA, 0);
        end
        chk(bus.ALU_EN == (n == exp_en_cyc), "alu_en", bus.ALU_EN, n == exp_en_cyc);
        chk(bus.CMD_READY == (n >= idle_from), "cmd_ready", bus.CMD_READY, n >= idle_from);
        chk(bus.BUSY == (n < idle_from), "busy", bus.BUSY, n < idle_from);
        chk(bus.TIMEOUT_ERR == (n == exp_to_cyc), "timeout_err", bus.TIMEOUT_ERR, n == exp_to_cyc);
        if (bus.TIMEOUT_ERR) begin
          last_to     = n;
          last_to_rdy = bus.CMD_READY;
        end
        if (n < idle_from) begin
          chk(bus.ALU_A == cmd_a,    "alu_a_stable",    bus.ALU_A, cmd_a);
          chk(bus.ALU_B == cmd_b,    "alu_b_stable",    bus.ALU_B, cmd_b);
          chk(bus.ALU_FUNC == cmd_f, "alu_func_stable", bus.ALU_FUNC, cmd_f);
        end
        if (bus.TX_VALID && !prev_vld) begin
          chk(n == exp_tx_start, "tx_first_cycle", n, exp_tx_start);
          last_rise = n;
        end
        if (n == exp_tx_start) chk(bus.TX_VALID == 1'b1, "tx_valid_start", bus.TX_VALID, 1);
        if (prev_vld && !prev_rdy && !prev_rst) begin
          chk(bus.TX_VALID == 1'b1,     "tx_hold_valid", bus.TX_VALID, 1);
          chk(bus.TX_DATA == prev_data, "tx_hold_data",  bus.TX_DATA, prev_data);
        end
        if (bus.TX_VALID && bus.TX_READY && !RST) begin
          chk(exp_q.size() != 0, "tx_extra_byte", bus.TX_DATA, exp_q.size());
          if (exp_q.size() != 0) begin
            chk(bus.TX_DATA == exp_q[0], "tx_byte", bus.TX_DATA, exp_q[0]);
            void'(exp_q.pop_front());
            tx_log.push_back(bus.TX_DATA);
            if (exp_q.size() == 0) idle_from = n + 1;
          end
        end
      end

      cmd_taken = 0;
      if (RST) begin
        started      = 1;
        rst_chk      = 1;
        exp_q.delete();
        exp_en_cyc   = -1;
        exp_tx_start = -1;
        exp_to_cyc   = -1;
        alu_vld_cyc  = -1;
        idle_from    = n + 1;
      end else begin
        rst_chk = 0;
        if (started && bus.CMD_VALID && bus.CMD_READY) begin
          cmd_a       = bus.CMD_A;
          cmd_b       = bus.CMD_B;
          cmd_f       = bus.CMD_FUNC;
          exp_en_cyc  = n + 1;
          idle_from   = INF;
          last_accept = n;
          cmd_taken   = 1;
        end
        if (n == exp_en_cyc) begin
          last_en    = n;
          last_alu_a = bus.ALU_A;
          last_alu_b = bus.ALU_B;
          if (force_d > 0) d = force_d;
          else if ($urandom % 4 == 0) d = $urandom_range(1, TC + 2);
          else d = $urandom_range(1, 3);
          alu_val     = alu_fn(cmd_a, cmd_b, cmd_f);
          alu_vld_cyc = n + d;
          // WAIT occupies cycles n+1 .. n+TC.
          if (d <= TC) begin
            exp_tx_start = n + d + 1;
            exp_q.push_back(alu_val[7:0]);
            if (cmd_f[3:2] == 2'b00) exp_q.push_back(alu_val[15:8]);
          end else begin
            exp_to_cyc = n + TC + 1;
            idle_from  = n + TC + 1;
          end
        end
      end
      prev_vld  = bus.TX_VALID;
      prev_rdy  = bus.TX_READY;
      prev_rst  = RST;
      prev_data = bus.TX_DATA;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    bit got = 0;
    bus.CMD_A = a;
    bus.CMD_B = b;
    bus.CMD_FUNC = f;
    bus.CMD_VALID = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge CLK);
      if (bus.CMD_VALID && bus.CMD_READY && !RST) got = 1;
    end
    tick();
    bus.CMD_VALID = 1'b0;
    chk(got, "cmd_accept", got, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (cyc >= idle_from && !bus.TX_VALID) ok = 1;
    end
    chk(ok, "idle_reached", ok, 1);
    tick();
  endtask

  task automatic wait_tx_vld();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (bus.TX_VALID) ok = 1;
    end
    chk(ok, "tx_valid_seen", ok, 1);
  endtask

  task automatic check_log(input string nm, input logic [7:0] e0, input logic [7:0] e1, input int cnt);
    chk(tx_log.size() == cnt, {nm, "_byte_count"}, tx_log.size(), cnt);
    if (cnt > 0 && tx_log.size() > 0) chk(tx_log[0] == e0, {nm, "_byte0"}, tx_log[0], e0);
    if (cnt > 1 && tx_log.size() > 1) chk(tx_log[1] == e1, {nm, "_byte1"}, tx_log[1], e1);
  endtask

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_A     = '0;
    bus.CMD_B     = '0;
    bus.CMD_FUNC  = '0;
    bus.TX_READY  = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();

    // Arithmetic, two bytes, ALU answers one cycle after enable.
    force_d = 1;
    tx_log.delete();
    send_cmd(8'h7F, 8'h02, 4'b0000);
    wait_idle();
    check_log("arith", 8'h81, 8'h00, 2);
    chk(last_en - last_accept == 1, "arith_en_latency", last_en - last_accept, 1);
    chk(last_rise - last_accept == 3, "arith_tx_latency", last_rise - last_accept, 3);
    chk(last_alu_a == 8'h7F, "arith_alu_a", last_alu_a, 8'h7F);
    chk(last_alu_b == 8'h02, "arith_alu_b", last_alu_b, 8'h02);

    // Logic class, single byte.
    tx_log.delete();
    send_cmd(8'hA5, 8'hFF, 4'b0100);
    wait_idle();
    check_log("logic", 8'hA5, 8'h00, 1);

    // Backpressure for 5 cycles in SEND_LO.
    bus.TX_READY = 1'b0;
    tx_log.delete();
    send_cmd(8'h7F, 8'h02, 4'b0000);
    wait_tx_vld();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      chk(bus.TX_VALID == 1'b1 && bus.TX_DATA == 8'h81, "bp_hold_81", {bus.TX_VALID, bus.TX_DATA}, 9'h181);
    end
    tick();
    bus.TX_READY = 1'b1;
    wait_idle();
    check_log("bp", 8'h81, 8'h00, 2);

    // Timeout: no valid inside WAIT (answer arrives one cycle too late).
    force_d = TC + 1;
    last_to = -1;
    tx_log.delete();
    send_cmd(8'h11, 8'h22, 4'b0000);
    wait_idle();
    tick();
    chk(last_to - last_en == 16, "timeout_cycle", last_to - last_en, 16);
    chk(last_to_rdy == 1'b1, "timeout_with_ready", last_to_rdy, 1);
    chk(tx_log.size() == 0, "timeout_no_tx", tx_log.size(), 0);

    // Valid in the final WAIT cycle is accepted.
    force_d = TC;
    last_to = -1;
    tx_log.delete();
    send_cmd(8'h11, 8'h22, 4'b0000);
    wait_idle();
    check_log("last_wait", 8'h33, 8'h00, 2);
    chk(last_to == -1, "last_wait_no_timeout", last_to, 32'hFFFFFFFF);

    // Reset in the middle of WAIT, then a normal command.
    force_d = TC + 1;
    last_to = -1;
    tx_log.delete();
    send_cmd(8'h01, 8'h02, 4'b0000);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wait_idle();
    repeat (TC) tick();
    chk(tx_log.size() == 0, "rst_wait_no_tx", tx_log.size(), 0);
    chk(last_to == -1, "rst_wait_no_timeout", last_to, 32'hFFFFFFFF);
    force_d = 2;
    send_cmd(8'h01, 8'h01, 4'b0000);
    wait_idle();
    check_log("after_rst_wait", 8'h02, 8'h00, 2);

    // Reset in the middle of SEND_HI, then a normal command.
    bus.TX_READY = 1'b0;
    force_d = 1;
    tx_log.delete();
    send_cmd(8'hFF, 8'hFF, 4'b0000);
    wait_tx_vld();
    tick();
    bus.TX_READY = 1'b1;
    tick();
    bus.TX_READY = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wait_idle();
    check_log("rst_send_hi", 8'hFE, 8'h00, 1);
    bus.TX_READY = 1'b1;
    tx_log.delete();
    send_cmd(8'h03, 8'h04, 4'b0001);
    wait_idle();
    check_log("after_rst_hi", 8'h0C, 8'h00, 2);

    // Random traffic: held command valid, stalls, stray valids, rare resets.
    force_d = 0;
    stray_en = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!bus.CMD_VALID || cmd_taken) begin
        bus.CMD_VALID = ($urandom % 3 != 0);
        bus.CMD_A     = 8'($urandom);
        bus.CMD_B     = 8'($urandom);
        bus.CMD_FUNC  = 4'($urandom);
      end
      bus.TX_READY = ($urandom % 4 != 0);
      RST = ($urandom % 250 == 0);
    end
    tick();
    bus.CMD_VALID = 1'b0;
    bus.TX_READY  = 1'b1;
    RST           = 1'b0;
    wait_idle();
    chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator and consumer for the ALU operation interface. The block does four things in order:
- accepts one operation command (A, B, function) from the system control path over a valid/ready handshake;
- drives the ALU operand and function bus with a single-cycle enable;
- waits for the ALU result-valid strobe, with a timeout;
- returns the result as one or two bytes on a valid/ready byte stream toward the serial transmit path.

Parameters:
- IN_DATA_WIDTH, 8: operand width of A and B.
- Arith_OUT_WIDTH, 16: ALU result width. Legal range is 9..16. The result is zero-extended to 16 bits internally.
- TIMEOUT_CYCLES, 15: maximum number of WAIT cycles allowed for ALU_OUT_VALID. Legal range is 1..255.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_A  in  IN_DATA_WIDTH  operand A.
- CMD_B  in  IN_DATA_WIDTH  operand B.
- CMD_FUNC  in  4  ALU function code. Bits [3:2] select the class; 2'b00 is the arithmetic class.
- ALU_A  out  IN_DATA_WIDTH  operand A to the ALU.
- ALU_B  out  IN_DATA_WIDTH  operand B to the ALU.
- ALU_FUNC  out  4  function code to the ALU.
- ALU_EN  out  1  ALU enable, one-cycle pulse per command.
- ALU_OUT  in  Arith_OUT_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result-valid strobe.
- TX_DATA  out  8  result byte.
- TX_VALID  out  1  result byte present.
- TX_READY  in  1  downstream accepts the byte.
- BUSY  out  1  high whenever the state is not IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse on ALU timeout.

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high. After the reset edge:
  - state = IDLE, CMD_READY = 1;
  - ALU_EN, TX_VALID, BUSY, TIMEOUT_ERR = 0;
  - ALU_A, ALU_B, ALU_FUNC, TX_DATA, result register and timeout counter = 0.
- Reset mid-operation (any state) aborts the command. TX_VALID drops, no TIMEOUT_ERR pulse, no byte is sent.
- States: IDLE, ISSUE, WAIT, SEND_LO, SEND_HI. ALU_EN, TX_VALID, CMD_READY and BUSY are Moore decodes of the state register.
- IDLE:
  - CMD_READY = 1.
  - On an edge with CMD_VALID & CMD_READY: latch CMD_A, CMD_B and CMD_FUNC into the ALU_A, ALU_B and ALU_FUNC registers, then go to ISSUE.
  - CMD_* inputs are ignored in every other state.
- ISSUE:
  - ALU_EN = 1 for exactly one cycle, then go to WAIT with the counter cleared.
  - ALU_A, ALU_B and ALU_FUNC stay stable from ISSUE until the state returns to IDLE.
- WAIT:
  - Counter increments every cycle.
  - If ALU_OUT_VALID = 1: capture ALU_OUT (zero-extended to 16 bits) and go to SEND_LO.
  - If WAIT cycle number TIMEOUT_CYCLES ends with no valid: go to IDLE, with TIMEOUT_ERR = 1 during the first IDLE cycle only. A valid arriving in that final WAIT cycle is accepted and is not a timeout.
  - ALU_OUT_VALID is ignored outside WAIT.
- SEND_LO:
  - TX_VALID = 1, TX_DATA = result[7:0].
  - Hold both until an edge with TX_READY = 1.
  - Then go to SEND_HI if the latched FUNC[3:2] == 2'b00, else to IDLE.
- SEND_HI:
  - TX_VALID = 1, TX_DATA = result[15:8].
  - Hold until TX_READY, then go to IDLE.
- TX rules:
  - TX_DATA is stable while TX_VALID is high and TX_READY is low.
  - TX_VALID never drops without a handshake, except on RST.
- Latency with an ALU that returns valid one cycle after ALU_EN:
  - command accepted at edge k;
  - ALU_EN high in cycle k+1;
  - valid seen in cycle k+2;
  - TX_VALID high from cycle k+3.
- Throughput: one command in flight. The next command is accepted in the first IDLE cycle after the last byte handshake.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.

Test Plan:
1. Arithmetic, 2 bytes: CMD A=8'h7F, B=8'h02, FUNC=4'b0000; ALU model returns 16'h0081 one cycle after ALU_EN; TX_READY = 1 → ALU_EN one cycle wide, ALU_A/B = 7F/02, TX bytes 0x81 then 0x00 on consecutive cycles, TX_VALID first high at k+3, CMD_READY back high the following cycle.
2. Logic class, 1 byte: FUNC=4'b0100, ALU returns 16'h00A5 → exactly one TX byte 0xA5, then IDLE.
3. Backpressure: repeat case 1 with TX_READY low for 5 cycles in SEND_LO → TX_VALID = 1 and TX_DATA = 0x81 constant for all 5 cycles; 0x00 follows after TX_READY rises; no byte lost or duplicated.
4. Timeout: ALU model never asserts valid; TIMEOUT_CYCLES = 15 → exactly 15 WAIT cycles; TIMEOUT_ERR high for one cycle, coinciding with CMD_READY = 1; no TX_VALID. Variant: valid in WAIT cycle 15 → result sent, no error.
5. Reset mid-WAIT and mid-SEND_HI: RST asserted for one cycle → next cycle in IDLE, all outputs at reset values, no TIMEOUT_ERR, no further TX bytes; the next command completes normally.
6. Back-to-back: CMD_VALID held high with 3 queued commands, ALU_OUT_VALID pulsed in IDLE between them → each accepted only in IDLE, one ALU_EN per command, stray valid ignored, byte order preserved.
